rvv_vector_writeback: RTL

- Writeback stage directly upstream of the vector register file write port.
- Accepts execution results over a valid/ready handshake, each carrying a per-byte enable, and buffers them in a small in-order FIFO.
- Drains one entry per cycle: reads the old destination register through a dedicated regfile read port, byte-merges the new data, then drives rd_addr/rd_data/rd_we.
- Publishes a pending-write bitmap so issue logic can stall on RAW hazards.

---
 rtl/rvv_vector_writeback_if.sv | 27 ++
 rtl/rvv_vector_writeback.sv | 111 +++++++++++
 2 files changed

// File: rtl/rvv_vector_writeback_if.sv
// Result handshake between vector execute and writeback.
// master drives the result, slave returns ready.
interface rvv_vector_writeback_if #(
    parameter int VLEN = 512
);
    logic              res_valid;
    logic              res_ready;
    logic [4:0]        res_vd;
    logic [VLEN-1:0]   res_data;
    logic [VLEN/8-1:0] res_be;

    modport master (
        output res_valid,
        output res_vd,
        output res_data,
        output res_be,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_vd,
        input  res_data,
        input  res_be,
        output res_ready
    );
endinterface

// File: rtl/rvv_vector_writeback.sv
// Vector writeback: in-order result FIFO, byte merge, pending bitmap.
// Optional same-cycle bypass into an empty FIFO: RVV_WB_BYPASS_EN.
module rvv_vector_writeback #(
    parameter int VLEN     = 512,
    parameter int NUM_REGS = 32,
    parameter int DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    rvv_vector_writeback_if.slave    res,
    output logic [4:0]               old_addr_o,
    input  logic [VLEN-1:0]          old_data_i,
    output logic [4:0]               rd_addr_o,
    output logic [VLEN-1:0]          rd_data_o,
    output logic                     rd_we_o,
    output logic [NUM_REGS-1:0]      pending_mask_o,
    output logic [$clog2(DEPTH):0]   wb_count_o
);
    localparam int NB = VLEN / 8;
    localparam int AW = $clog2(DEPTH);

    logic [4:0]      vd_q   [DEPTH];
    logic [VLEN-1:0] data_q [DEPTH];
    logic [NB-1:0]   be_q   [DEPTH];

    logic [AW:0]     wr_q, wr_d;
    logic [AW:0]     rd_q, rd_d;
    logic [AW:0]     cnt;
    logic [AW-1:0]   head;
    logic            empty;
    logic            byp;
    logic            push;
    logic            pop;
    logic            act;

    logic [4:0]      src_vd;
    logic [VLEN-1:0] src_data;
    logic [NB-1:0]   src_be;

    assign cnt   = wr_q - rd_q;
    assign head  = rd_q[AW-1:0];
    assign empty = (cnt == '0);

    assign res.res_ready = (cnt != (AW+1)'(DEPTH));

`ifdef RVV_WB_BYPASS_EN
    assign byp = empty & res.res_valid;
`else
    assign byp = 1'b0;
`endif

    // A bypassed result is written directly and never occupies a slot.
    assign push = res.res_valid & res.res_ready & ~byp;
    assign pop  = ~empty;
    assign act  = byp | ~empty;

    assign src_vd   = byp ? res.res_vd   : vd_q[head];
    assign src_data = byp ? res.res_data : data_q[head];
    assign src_be   = byp ? res.res_be   : be_q[head];

    assign old_addr_o = act ? src_vd : 5'd0;
    assign rd_addr_o  = act ? src_vd : 5'd0;
    assign rd_we_o    = act & (|src_be);

    always_comb begin
        rd_data_o = '0;
        if (act) begin
            for (int i = 0; i < NB; i++) begin
                rd_data_o[8*i +: 8] = src_be[i] ? src_data[8*i +: 8]
                                                : old_data_i[8*i +: 8];
            end
        end
    end

    // Slot i is live when its distance from the head is below occupancy.
    always_comb begin
        pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, AW'(AW'(i) - head)} < cnt) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (vd_q[i] == 5'(r)) begin
                        pending_mask_o[r] = 1'b1;
                    end
                end
            end
        end
    end

    assign wb_count_o = cnt;

    assign wr_d = wr_q + (AW+1)'(push);
    assign rd_d = rd_q + (AW+1)'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            vd_q[wr_q[AW-1:0]]   <= res.res_vd;
            data_q[wr_q[AW-1:0]] <= res.res_data;
            be_q[wr_q[AW-1:0]]   <= res.res_be;
        end
    end
endmodule
